// File: rtl/unpack_normalize_float64.sv
// Unpacks a binary64 operand into sign, 13-bit exponent and 64-bit significand (leading one at
// bit 62), normalizing subnormals one shift step per cycle behind an ap_start/ap_done handshake.
module unpack_normalize_float64 (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld,
  output logic        zSign,
  output logic [12:0] zExp,
  output logic [63:0] zSig,
  output logic        isNaN,
  output logic        isInf,
  output logic        isZero
);

  typedef enum logic [3:0] {
    StIdle     = 4'b0001,
    StClassify = 4'b0010,
    StNorm     = 4'b0100,
    StDone     = 4'b1000
  } state_e;

  state_e      state_q;
  logic [63:0] a_q;
  logic [52:0] w_q;
  logic [5:0]  s_q;
  logic        z_sign_q;
  logic [12:0] z_exp_q;
  logic [63:0] z_sig_q;
  logic        is_nan_q;
  logic        is_inf_q;
  logic        is_zero_q;

  logic [10:0] exp_f;
  logic [51:0] frac_f;
  logic        exp_max;
  logic        exp_min;
  logic        frac_zero;
  logic [52:0] w_shift;
  logic [5:0]  s_next;

  always_comb begin
    exp_f     = a_q[62:52];
    frac_f    = a_q[51:0];
    exp_max   = (exp_f == 11'h7FF);
    exp_min   = (exp_f == 11'h000);
    frac_zero = (frac_f == 52'd0);
    // Coarse 8-bit step while the top byte is empty; it can never push the leading one past bit 52.
    if (w_q[52:45] == 8'd0) begin
      w_shift = {w_q[44:0], 8'd0};
      s_next  = s_q + 6'd8;
    end else begin
      w_shift = {w_q[51:0], 1'b0};
      s_next  = s_q + 6'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= StIdle;
      a_q       <= 64'd0;
      w_q       <= 53'd0;
      s_q       <= 6'd0;
      z_sign_q  <= 1'b0;
      z_exp_q   <= 13'd0;
      z_sig_q   <= 64'd0;
      is_nan_q  <= 1'b0;
      is_inf_q  <= 1'b0;
      is_zero_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ap_start) begin
            a_q     <= a;
            state_q <= StClassify;
          end
        end
        StClassify: begin
          if (exp_min && !frac_zero) begin
            w_q     <= {1'b0, frac_f};
            s_q     <= 6'd0;
            state_q <= StNorm;
          end else begin
            z_sign_q <= a_q[63];
            if (exp_max) begin
              z_exp_q   <= 13'h07FF;
              z_sig_q   <= {2'b00, frac_f, 10'd0};
              is_nan_q  <= !frac_zero;
              is_inf_q  <= frac_zero;
              is_zero_q <= 1'b0;
            end else if (exp_min) begin
              z_exp_q   <= 13'd0;
              z_sig_q   <= 64'd0;
              is_nan_q  <= 1'b0;
              is_inf_q  <= 1'b0;
              is_zero_q <= 1'b1;
            end else begin
              z_exp_q   <= {2'b00, exp_f};
              z_sig_q   <= {2'b01, frac_f, 10'd0};
              is_nan_q  <= 1'b0;
              is_inf_q  <= 1'b0;
              is_zero_q <= 1'b0;
            end
            state_q <= StDone;
          end
        end
        StNorm: begin
          w_q <= w_shift;
          s_q <= s_next;
          if (w_shift[52]) begin
            z_sign_q  <= a_q[63];
            z_exp_q   <= 13'd1 - {7'd0, s_next};
            z_sig_q   <= {1'b0, w_shift, 10'd0};
            is_nan_q  <= 1'b0;
            is_inf_q  <= 1'b0;
            is_zero_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ap_done  = (state_q == StDone);
    ap_ready = ap_done;
    ap_idle  = (state_q == StIdle) && !ap_start;
    // Signaling NaN: exponent all ones, nonzero fraction, quiet bit clear.
    float_exception_flag_o_ap_vld = (state_q == StClassify) && exp_max && !frac_zero &&
                                    !frac_f[51];
    float_exception_flag_o = float_exception_flag_o_ap_vld ?
                             (float_exception_flag_i | 32'h10) : float_exception_flag_i;
    zSign  = z_sign_q;
    zExp   = z_exp_q;
    zSig   = z_sig_q;
    isNaN  = is_nan_q;
    isInf  = is_inf_q;
    isZero = is_zero_q;
  end

endmodule
